// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline enable/bubble sequencer with mult/div handshake and watchdog
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic             branch_taken,
    input  logic             md_ready,
    input  logic             md_exc,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_bubble,
    output logic             dx_en,
    output logic             dx_bubble,
    output logic             xm_en,
    output logic             xm_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic {RUN, MD_WAIT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       timeout_hit;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       dx_lw, dx_md, fd_uses_rd, load_use;

    assign fd_op    = fd_ir[31:27];
    assign fd_rd    = fd_ir[26:22];
    assign fd_rs    = fd_ir[21:17];
    assign fd_rt    = fd_ir[16:12];
    assign dx_op    = dx_ir[31:27];
    assign dx_rd    = dx_ir[26:22];
    assign dx_aluop = dx_ir[6:2];

    // md_exc travels with the result through the datapath; the sequencer never acts on it
    logic unused_bits;
    assign unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0], md_exc};

    assign dx_lw      = (dx_op == 5'b01000);
    assign dx_md      = (dx_op == 5'b00000) && (dx_aluop == 5'b00110 || dx_aluop == 5'b00111);
    // sw, bne, blt and jr read their rd field as a source operand
    assign fd_uses_rd = (fd_op == 5'b00111) || (fd_op == 5'b00010) ||
                        (fd_op == 5'b00110) || (fd_op == 5'b00100);
    assign load_use   = dx_lw && (dx_rd != 5'd0) &&
                        ((dx_rd == fd_rs) || (dx_rd == fd_rt) || (fd_uses_rd && (dx_rd == fd_rd)));

    always_comb begin
        pc_en       = 1'b0;
        fd_en       = 1'b0;
        fd_bubble   = 1'b0;
        dx_en       = 1'b0;
        dx_bubble   = 1'b0;
        xm_en       = 1'b0;
        xm_bubble   = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        timeout_hit = 1'b0;
        next_state  = state;
        if (reset_n) begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
                        fd_bubble = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (dx_md) begin
                        md_start   = 1'b1;
                        xm_en      = 1'b1;
                        xm_bubble  = 1'b1;
                        next_state = MD_WAIT;
                    end else if (load_use) begin
                        dx_en     = 1'b1;
                        dx_bubble = 1'b1;
                        xm_en     = 1'b1;
                    end else begin
                        {pc_en, fd_en, dx_en, xm_en} = 4'b1111;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    xm_en   = 1'b1;
                    if (md_ready) begin
                        {pc_en, fd_en, dx_en} = 3'b111;
                        next_state = RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // watchdog expiry: drop the mul/div and let the pipeline move on
                        {pc_en, fd_en, dx_en} = 3'b111;
                        xm_bubble   = 1'b1;
                        timeout_hit = 1'b1;
                        next_state  = RUN;
                    end else begin
                        xm_bubble = 1'b1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            wait_cnt   <= 8'd0;
            md_timeout <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == MD_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
            if (timeout_hit)
                md_timeout <= 1'b1;
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    localparam int MD_TO   = 40;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {pc_en, fd_en, fd_bubble, dx_en, dx_bubble, xm_en, xm_bubble, md_start, md_busy}
    localparam logic [8:0] V_RST  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] V_ALL  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] V_BR   = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] V_MDS  = 9'b0_0_0_0_0_1_1_1_0;
    localparam logic [8:0] V_LU   = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] V_WAIT = 9'b0_0_0_0_0_1_1_0_1;
    localparam logic [8:0] V_REL  = 9'b1_1_0_1_0_1_0_0_1;
    localparam logic [8:0] V_TOUT = 9'b1_1_0_1_0_1_1_0_1;

    localparam logic [31:0] NOP     = 32'h0;
    localparam logic [31:0] LW_R5   = {5'b01000, 5'd5, 22'd0};
    localparam logic [31:0] LW_R0   = {5'b01000, 5'd0, 22'd0};
    localparam logic [31:0] ADD_R5  = {5'b00000, 5'd1, 5'd5, 5'd2, 5'd0, 5'b00001, 2'b00};
    localparam logic [31:0] ADD_R0  = {5'b00000, 5'd1, 5'd0, 5'd0, 5'd0, 5'b00001, 2'b00};
    localparam logic [31:0] ADD_RD5 = {5'b00000, 5'd5, 5'd6, 5'd7, 5'd0, 5'b00001, 2'b00};
    localparam logic [31:0] SW_R5   = {5'b00111, 5'd5, 5'd6, 5'd7, 12'd0};
    localparam logic [31:0] MUL     = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00110, 2'b00};
    localparam logic [31:0] DIV     = {5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'b00111, 2'b00};

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      fd_ir, dx_ir;
    logic             branch_taken, md_ready, md_exc;
    logic             pc_en, fd_en, fd_bubble, dx_en, dx_bubble, xm_en, xm_bubble;
    logic             md_start, md_busy, md_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [8:0]       outs;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    assign outs = {pc_en, fd_en, fd_bubble, dx_en, dx_bubble, xm_en, xm_bubble, md_start, md_busy};

    hazard_stall_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .fd_ir(fd_ir), .dx_ir(dx_ir),
        .branch_taken(branch_taken), .md_ready(md_ready), .md_exc(md_exc),
        .pc_en(pc_en), .fd_en(fd_en), .fd_bubble(fd_bubble), .dx_en(dx_en),
        .dx_bubble(dx_bubble), .xm_en(xm_en), .xm_bubble(xm_bubble),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                       input logic rdy, input logic [8:0] exp, input string tag);
        @(negedge clk);
        fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy;
        #1;
        chk(tag, 32'(outs), 32'(exp));
        if (!exp[8] && exp_stall < CNT_MAX) exp_stall++;
    endtask

    task automatic regs(input string tag, input logic exp_to);
        @(posedge clk); #1;
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_to"}, 32'(md_timeout), 32'(exp_to));
    endtask

    initial begin
        reset_n = 1'b0; fd_ir = NOP; dx_ir = MUL; branch_taken = 1'b0; md_ready = 1'b0; md_exc = 1'b0;
        #1;
        chk("rst_outs", 32'(outs), 32'(V_RST));
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_to", 32'(md_timeout), 32'd0);
        @(negedge clk); dx_ir = NOP; reset_n = 1'b1;

        cyc(NOP, NOP, 1'b0, 1'b0, V_ALL, "idle");
        cyc(ADD_R5, LW_R5, 1'b0, 1'b0, V_LU, "lu_rs");
        regs("lu_rs", 1'b0);
        cyc(ADD_R5, NOP, 1'b0, 1'b0, V_ALL, "lu_after");
        cyc(SW_R5, LW_R5, 1'b0, 1'b0, V_LU, "lu_sw_rd");
        cyc(ADD_RD5, LW_R5, 1'b0, 1'b0, V_ALL, "no_lu_rd");
        cyc(ADD_R0, LW_R0, 1'b0, 1'b0, V_ALL, "lw_r0");
        regs("after_lu", 1'b0);

        cyc(NOP, MUL, 1'b0, 1'b0, V_MDS, "mul_start");
        cyc(NOP, MUL, 1'b0, 1'b0, V_WAIT, "mul_w1");
        cyc(NOP, MUL, 1'b0, 1'b0, V_WAIT, "mul_w2");
        cyc(NOP, MUL, 1'b0, 1'b1, V_REL, "mul_rel");
        regs("mul", 1'b0);
        cyc(NOP, MUL, 1'b0, 1'b0, V_MDS, "b2b_start");
        cyc(NOP, MUL, 1'b0, 1'b1, V_REL, "b2b_rel");
        cyc(NOP, NOP, 1'b0, 1'b1, V_ALL, "rdy_in_run");
        cyc(NOP, MUL, 1'b1, 1'b0, V_BR, "br_mul");
        cyc(NOP, NOP, 1'b0, 1'b0, V_ALL, "br_stay_run");
        regs("br", 1'b0);

        cyc(NOP, DIV, 1'b0, 1'b0, V_MDS, "div_start");
        cyc(NOP, DIV, 1'b1, 1'b0, V_WAIT, "wait_ign_br");
        for (int i = 1; i < MD_TO - 1; i++)
            cyc(NOP, DIV, 1'b0, 1'b0, V_WAIT, "div_wait");
        chk("to_not_yet", 32'(md_timeout), 32'd0);
        cyc(NOP, DIV, 1'b0, 1'b0, V_TOUT, "div_tout");
        regs("tout", 1'b1);
        cyc(NOP, NOP, 1'b0, 1'b0, V_ALL, "resume");
        cyc(NOP, NOP, 1'b0, 1'b1, V_ALL, "resume2");
        regs("sticky", 1'b1);

        cyc(NOP, MUL, 1'b0, 1'b0, V_MDS, "rst_mul_start");
        cyc(NOP, MUL, 1'b0, 1'b0, V_WAIT, "rst_mul_wait");
        #2 reset_n = 1'b0;
        #1;
        chk("arst_outs", 32'(outs), 32'(V_RST));
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_to", 32'(md_timeout), 32'd0);
        exp_stall = 0;
        @(negedge clk); dx_ir = NOP; reset_n = 1'b1;
        cyc(NOP, NOP, 1'b0, 1'b0, V_ALL, "post_rst_run");

        for (int i = 0; i < CNT_MAX - 1; i++)
            cyc(ADD_R5, LW_R5, 1'b0, 1'b0, V_LU, "sat_fill");
        regs("sat_below", 1'b0);
        chk("sat_below_val", 32'(stall_cnt), 32'(CNT_MAX - 1));
        for (int i = 0; i < 8; i++)
            cyc(ADD_R5, LW_R5, 1'b0, 1'b0, V_LU, "sat_hold");
        regs("sat_top", 1'b0);
        chk("sat_top_val", 32'(stall_cnt), 32'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
